xalu: RTL and testbench
=======================

# xalu

Multiply/divide unit of the E stage, directly downstream of the pipeline control block. It consumes the E-stage `E_XAluOp` and `E_Start` decodes together with the forwarded E-stage operands. It produces `Busy`, which the control block's stall logic consumes, and `Out`, which feeds the E-stage ALU result select. HI/LO are architectural state owned here; results commit after a fixed multi-cycle latency.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu/madd/maddu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: synchronous, active-high; clears all state.
- `Start  in  1`: pulse while E holds a mult/div-class instruction.
- `XAluOp  in  4`: operation code, `xaluop_size`, codes in `head.v`.
- `A  in  32`: rs operand, forwarded.
- `B  in  32`: rt operand, forwarded.
- `Busy  out  1`: registered; high while an operation is in flight.
- `HI  out  32`: architectural HI.
- `LO  out  32`: architectural LO.
- `Out  out  32`: combinational. HI when op is mfhi, LO when op is mflo, else 0.

## Operation
- Op codes:
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
  - 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO
  - 9 MADD, 10 MADDU (9 and 10 only with the macro)
- Accepting an operation (`Start`=1, `Busy`=0, op in {1,2,3,4,9,10}):
  - Capture the 64-bit result into pending registers PH/PL.
  - Load the counter with the op's cycle count; set `Busy`.
- Result rules:
  - MULT: signed 32x32→64.
  - MULTU: unsigned 32x32→64.
  - DIV: LO=quotient, HI=remainder, truncating toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - MADD/MADDU: {HI,LO} + product, with signed or unsigned product respectively. Wraps mod 2^64. The HI/LO value at the start edge is used.
  - Divide by zero (B=0): PH/PL are loaded with the current HI/LO, so the commit leaves HI/LO unchanged. Busy still runs the full DIV_CYCLES.
- Counter and commit: the counter decrements each cycle while `Busy`. On the edge where it reaches zero, HI←PH, LO←PL and `Busy`←0.
- MTHI/MTLO: on the edge with the op present and `Busy`=0, HI←A or LO←A. No Busy. Ignored while `Busy`.
- MFHI/MFLO: `Out` returns the committed HI/LO. HI/LO are never bypassed from PH/PL.
- Ignored inputs:
  - `Start` while `Busy` is ignored, because the controller stalls it.
  - `Start` with a non-mult/div op is ignored.

## Timing
- Reset values: `Busy`=0, HI=0, LO=0, counter=0, PH=PL=0. `Out`=0 unless op is MFHI/MFLO.
- Reset asserted mid-operation aborts the operation. The pending result is discarded and Busy is 0 after the edge.
- State machine: IDLE → (accept) → BUSY(count) → (count hits zero) → IDLE.
- Latency: with Start sampled at edge T:
  - `Busy` is high from after edge T until edge T+N, for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO change at edge T+N.
  - An MFHI issued in the cycle after Busy falls reads the new value.
- In the Start cycle itself `Busy`=0. The controller stalls on `E_Start|Busy`.
- Back-to-back: a new Start in the first cycle after Busy falls is accepted.

## Configuration
- `XALU_MADD_EN`:
  - Defined: op codes 9 and 10 accumulate as specified above, with MULT_CYCLES latency.
  - Undefined: codes 9 and 10 are treated as NOP. `Start` with them is ignored, Busy stays 0 and HI/LO are unchanged.

## Structure
- XAluOp codes, `xaluop_size`, and the default cycle counts live in `head.v` beside the other control encodings.
- One sub-module, `xalu_core`: a combinational 64-bit result generator driven by (op, A, B, HI, LO), returning {PH,PL} including the div-by-zero hold.
- The counter, FSM, and HI/LO/PH/PL registers sit in `xalu`.

## Test plan
- Reset, then MULT with A=0xFFFFFFFF, B=2 →
  - Busy=1 for exactly 5 cycles.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFE at edge T+5; HI/LO remain 0 before then.
- MULTU with A=0xFFFFFFFF, B=2 → HI=1, LO=0xFFFFFFFE. DIV with A=-7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI A=0x1234 with Busy=0 → HI=0x1234 next edge, Busy stays 0. MTLO issued during a DIV is ignored.
- DIVU with B=0 after MTLO 5 → Busy runs 10 cycles, LO still 5 afterwards.
- Reset asserted on cycle 3 of a DIV → Busy=0 and HI=LO=0 after the edge. A subsequent MULT 3×4 gives LO=12.
- With `XALU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 → HI=1, LO=0 after 5 cycles. Without the macro, the same op leaves Busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/xalu_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: op codes, default latencies, FSM states.
// XALU_MADD_EN enables the MADD/MADDU accumulate ops (codes 9 and 10).
package xalu_pkg;

  localparam int XALUOP_SIZE     = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [XALUOP_SIZE-1:0] {
    XOP_NOP   = 4'd0,
    XOP_MULT  = 4'd1,
    XOP_MULTU = 4'd2,
    XOP_DIV   = 4'd3,
    XOP_DIVU  = 4'd4,
    XOP_MTHI  = 4'd5,
    XOP_MTLO  = 4'd6,
    XOP_MFHI  = 4'd7,
    XOP_MFLO  = 4'd8,
    XOP_MADD  = 4'd9,
    XOP_MADDU = 4'd10
  } xaluop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Ops that occupy the unit for a multi-cycle latency; MADD/MADDU only exist with the feature on.
  function automatic logic is_long_op(input logic [XALUOP_SIZE-1:0] op);
    case (op)
      XOP_MULT, XOP_MULTU, XOP_DIV, XOP_DIVU: return 1'b1;
`ifdef XALU_MADD_EN
      XOP_MADD, XOP_MADDU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_mult_class(input logic [XALUOP_SIZE-1:0] op);
    case (op)
      XOP_MULT, XOP_MULTU, XOP_MADD, XOP_MADDU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/xalu_core.sv
// Combinational 64-bit result generator: returns {PH,PL} for the op, holding {HI,LO} on divide by zero.
// XALU_MADD_EN adds the MADD/MADDU accumulate paths.
module xalu_core
  import xalu_pkg::*;
(
  input  logic [XALUOP_SIZE-1:0] op,
  input  logic [31:0]            a,
  input  logic [31:0]            b,
  input  logic [31:0]            hi,
  input  logic [31:0]            lo,
  output logic [63:0]            res
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        div_zero;
  logic [31:0] udivisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] sdivisor;
  logic [31:0] mq;
  logic [31:0] mr;
  logic [31:0] sq;
  logic [31:0] sr;

  assign sprod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod    = {32'd0, a} * {32'd0, b};
  assign div_zero = (b == 32'd0);

  // Divisors are forced to 1 on zero so the dividers never see an undefined case; the result is discarded anyway.
  assign udivisor = div_zero ? 32'd1 : b;
  assign uq       = a / udivisor;
  assign ur       = a % udivisor;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend sign.
  assign abs_a    = a[31] ? (32'd0 - a) : a;
  assign abs_b    = b[31] ? (32'd0 - b) : b;
  assign sdivisor = div_zero ? 32'd1 : abs_b;
  assign mq       = abs_a / sdivisor;
  assign mr       = abs_a % sdivisor;
  assign sq       = (a[31] ^ b[31]) ? (32'd0 - mq) : mq;
  assign sr       = a[31] ? (32'd0 - mr) : mr;

  always_comb begin
    res = 64'd0;
    case (op)
      XOP_MULT:  res = sprod;
      XOP_MULTU: res = uprod;
      XOP_DIV:   res = div_zero ? {hi, lo} : {sr, sq};
      XOP_DIVU:  res = div_zero ? {hi, lo} : {ur, uq};
`ifdef XALU_MADD_EN
      XOP_MADD:  res = {hi, lo} + sprod;
      XOP_MADDU: res = {hi, lo} + uprod;
`endif
      default:   res = 64'd0;
    endcase
  end

endmodule

// File: rtl/xalu.sv
// E-stage multiply/divide unit: owns HI/LO, captures results at issue and commits them after a fixed latency.
// XALU_MADD_EN enables MADD/MADDU; without it those codes behave as NOP.
module xalu
  import xalu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [XALUOP_SIZE-1:0] XAluOp,
  input  logic [31:0]            A,
  input  logic [31:0]            B,
  output logic                   Busy,
  output logic [31:0]            HI,
  output logic [31:0]            LO,
  output logic [31:0]            Out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_count;
  logic [31:0]      ph;
  logic [31:0]      pl;
  logic [63:0]      core_res;
  logic             accept;
  logic             commit;
  logic             mthi_we;
  logic             mtlo_we;

  xalu_core u_core (
    .op  (XAluOp),
    .a   (A),
    .b   (B),
    .hi  (HI),
    .lo  (LO),
    .res (core_res)
  );

  assign accept     = Start && (state == ST_IDLE) && is_long_op(XAluOp);
  assign commit     = (state == ST_BUSY) && (count == CNT_W'(1));
  assign load_count = is_mult_class(XAluOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
  assign mthi_we    = (state == ST_IDLE) && (XAluOp == XOP_MTHI);
  assign mtlo_we    = (state == ST_IDLE) && (XAluOp == XOP_MTLO);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_BUSY;
      ST_BUSY: if (commit) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == ST_BUSY);
    Out  = 32'd0;
    if (XAluOp == XOP_MFHI) begin
      Out = HI;
    end else if (XAluOp == XOP_MFLO) begin
      Out = LO;
    end
  end

  // The pending result is frozen at issue so later HI/LO moves cannot leak into it; HI/LO only change at commit or MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      ph    <= 32'd0;
      pl    <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      if (accept) begin
        count <= load_count;
        ph    <= core_res[63:32];
        pl    <= core_res[31:0];
      end else if (state == ST_BUSY) begin
        count <= count - CNT_W'(1);
      end
      if (commit) begin
        HI <= ph;
        LO <= pl;
      end
      if (mthi_we) HI <= A;
      if (mtlo_we) LO <= A;
    end
  end

endmodule

// File: tb/tb_xalu.sv
// Scoreboard bench for xalu: stimulus queues expected commits and state probes, a negedge monitor checks them.
// Build with XALU_MADD_EN defined to exercise the accumulate ops.
module tb_xalu;
  import xalu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } commit_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic [31:0] out;
  } probe_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  XAluOp = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  logic        probe = 1'b0;
  int          assertions = 0;
  int          failures = 0;
  commit_t     commit_q[$];
  probe_t      probe_q[$];

  xalu dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .XAluOp (XAluOp),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO),
    .Out    (Out)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a falling Busy (outside reset) presents a commit; a probe strobe presents a state snapshot.
  initial begin
    logic    prev_busy;
    int      busy_len;
    commit_t c;
    probe_t  p;
    prev_busy = 1'b0;
    busy_len  = 0;
    forever begin
      @(negedge clk);
      if (Busy === 1'b1) busy_len++;
      if (prev_busy === 1'b1 && Busy === 1'b0 && reset === 1'b0) begin
        if (commit_q.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL unexpected_commit: HI=0x%08h LO=0x%08h, no result expected", HI, LO);
        end else begin
          c = commit_q.pop_front();
          check_value({c.name, "_hi"}, HI, c.hi);
          check_value({c.name, "_lo"}, LO, c.lo);
          check_value({c.name, "_busy_cycles"}, busy_len, c.cycles);
        end
      end
      if (Busy !== 1'b1) busy_len = 0;
      if (probe) begin
        if (probe_q.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL probe_underflow: got strobe, expected queued probe");
        end else begin
          p = probe_q.pop_front();
          check_value({p.name, "_hi"}, HI, p.hi);
          check_value({p.name, "_lo"}, LO, p.lo);
          check_value({p.name, "_busy"}, {31'd0, Busy}, {31'd0, p.busy});
          check_value({p.name, "_out"}, Out, p.out);
        end
      end
      prev_busy = Busy;
    end
  end

  // Drives one op for exactly one sampling edge; called and returns just after a rising edge.
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic start);
    Start  = start;
    XAluOp = op;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
    Start  = 1'b0;
    XAluOp = XOP_NOP;
    A      = 32'd0;
    B      = 32'd0;
  endtask

  // Queues a snapshot of the state left by the previous edge, with op driven so Out can be checked.
  task automatic check_output(input string name, input logic [3:0] op, input logic [31:0] hi,
                              input logic [31:0] lo, input logic busy, input logic [31:0] out);
    probe_t p;
    p.name = name;
    p.hi   = hi;
    p.lo   = lo;
    p.busy = busy;
    p.out  = out;
    probe_q.push_back(p);
    XAluOp = op;
    probe  = 1'b1;
    @(posedge clk);
    #1;
    probe  = 1'b0;
    XAluOp = XOP_NOP;
  endtask

  task automatic expect_commit(input string name, input logic [31:0] hi, input logic [31:0] lo,
                               input int cycles);
    commit_t c;
    c.name   = name;
    c.hi     = hi;
    c.lo     = lo;
    c.cycles = cycles;
    commit_q.push_back(c);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    assertions++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_timeout: Busy=%b after %0d cycles, expected 0", name, Busy, n);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("reset_state", XOP_NOP, 32'd0, 32'd0, 1'b0, 32'd0);
    check_output("reset_mfhi", XOP_MFHI, 32'd0, 32'd0, 1'b0, 32'd0);

    // Signed multiply with latency probes before the commit edge.
    expect_commit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    apply_stimulus(XOP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1);
    check_output("mult_t1", XOP_NOP, 32'd0, 32'd0, 1'b1, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_output("mult_t4", XOP_MFHI, 32'd0, 32'd0, 1'b1, 32'd0);
    wait_idle("mult");
    check_output("mult_mfhi", XOP_MFHI, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF);
    check_output("mult_mflo", XOP_MFLO, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE);

    // Back-to-back issues, each Start in the first cycle after Busy falls.
    expect_commit("multu", 32'd1, 32'hFFFF_FFFE, 5);
    expect_commit("div_neg_dividend", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    expect_commit("div_neg_divisor", 32'd1, 32'hFFFF_FFFD, 10);
    apply_stimulus(XOP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle("multu");
    apply_stimulus(XOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle("div_neg_dividend");
    apply_stimulus(XOP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_idle("div_neg_divisor");

    apply_stimulus(XOP_MTHI, 32'h0000_1234, 32'd0, 1'b1);
    check_output("mthi", XOP_NOP, 32'h0000_1234, 32'hFFFF_FFFD, 1'b0, 32'd0);

    // MTLO during a divide must not disturb LO.
    expect_commit("div_100_7", 32'd2, 32'd14, 10);
    apply_stimulus(XOP_DIV, 32'd100, 32'd7, 1'b1);
    apply_stimulus(XOP_MTLO, 32'h0000_DEAD, 32'd0, 1'b1);
    check_output("mtlo_ignored", XOP_MFLO, 32'h0000_1234, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFD);
    wait_idle("div_100_7");

    apply_stimulus(XOP_MTLO, 32'd5, 32'd0, 1'b1);
    check_output("mtlo", XOP_MFLO, 32'd2, 32'd5, 1'b0, 32'd5);
    expect_commit("divu_by_zero", 32'd2, 32'd5, 10);
    apply_stimulus(XOP_DIVU, 32'd9, 32'd0, 1'b1);
    wait_idle("divu_by_zero");
    check_output("divu_by_zero_mflo", XOP_MFLO, 32'd2, 32'd5, 1'b0, 32'd5);

    // Reset on the third cycle of a divide discards it.
    apply_stimulus(XOP_DIV, 32'd100, 32'd7, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    check_output("reset_abort", XOP_MFLO, 32'd0, 32'd0, 1'b0, 32'd0);
    expect_commit("mult_after_reset", 32'd0, 32'd12, 5);
    apply_stimulus(XOP_MULT, 32'd3, 32'd4, 1'b1);
    wait_idle("mult_after_reset");

    apply_stimulus(XOP_MTHI, 32'd0, 32'd0, 1'b1);
    apply_stimulus(XOP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b1);
    check_output("madd_setup", XOP_NOP, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'd0);
`ifdef XALU_MADD_EN
    expect_commit("maddu", 32'd1, 32'd0, 5);
    apply_stimulus(XOP_MADDU, 32'd1, 32'd1, 1'b1);
    check_output("maddu_busy", XOP_NOP, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'd0);
    wait_idle("maddu");
    expect_commit("madd", 32'd0, 32'hFFFF_FFFF, 5);
    apply_stimulus(XOP_MADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_idle("madd");
    check_output("madd_mflo", XOP_MFLO, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
`else
    apply_stimulus(XOP_MADDU, 32'd1, 32'd1, 1'b1);
    check_output("maddu_ignored", XOP_MADDU, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'd0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check_output("maddu_ignored_late", XOP_MFLO, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
`endif

    repeat (3) @(posedge clk);
    #1;
    check_value("commit_queue_drained", commit_q.size(), 32'd0);
    check_value("probe_queue_drained", probe_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
